// File: rtl/prog_loader.sv
// Program-memory loader: packs an MSB-first byte stream into i_size-bit words
// and writes them to sequential program-memory addresses, holding the core off via busy.
module prog_loader #(
  parameter int p_size = 6,
  parameter int i_size = 24
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [p_size-1:0] wr_addr,
  output logic [i_size-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start, all outputs low
  // RECV  | accepting bytes of the current word
  // WRITE | one-cycle write strobe of the assembled word
  // DONE  | full image written, waiting for a new start
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam int B  = i_size / 8;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BW-1:0]     BCNT_LAST = BW'(B - 1);
  localparam logic [p_size-1:0] ADDR_LAST = {p_size{1'b1}};

  state_t              state;
  logic [p_size-1:0]   addr;
  logic [BW-1:0]       bcnt;
  logic [i_size-1:0]   shreg;
  logic [i_size+7:0]   shifted;

  // Widened concatenation keeps the shift legal even when i_size is 8.
  assign shifted = {shreg, byte_in};

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      addr       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RECV;
            addr       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        RECV: begin
          if (byte_valid) begin
            shreg <= shifted[i_size-1:0];
            if (bcnt == BCNT_LAST) begin
              state      <= WRITE;
              bcnt       <= '0;
              byte_ready <= 1'b0;
              wr_en      <= 1'b1;
              wr_addr    <= addr;
              wr_data    <= shifted[i_size-1:0];
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        WRITE: begin
          wr_en <= 1'b0;
          if (addr == ADDR_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            addr       <= addr + 1'b1;
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes, a negedge
// monitor pops and compares every wr_en strobe and rebuilds the memory image.
module tb_prog_loader;

  localparam int P = 6;
  localparam int I = 24;
  localparam int DEPTH = 1 << P;

  logic         Clock = 1'b0;
  logic         nReset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   byte_in = '0;
  logic         byte_valid = 1'b0;
  logic         byte_ready;
  logic [P-1:0] wr_addr;
  logic [I-1:0] wr_data;
  logic         wr_en;
  logic         busy;
  logic         done;

  prog_loader #(.p_size(P), .i_size(I)) dut (
    .Clock(Clock), .nReset(nReset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;
  logic [P+I-1:0] exp_q[$];
  logic [I-1:0]   tb_mem[DEPTH];
  logic [I-1:0]   img[DEPTH];
  int             exp_addr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected word.
  always @(negedge Clock) begin
    if (nReset && wr_en) begin
      n_wr++;
      tb_mem[wr_addr] = wr_data;
      check("wr_ready_low", 64'(byte_ready), 64'd0);
      check("wr_busy", 64'(busy), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 64'(wr_addr), 64'hFFFF);
      end else begin
        logic [P+I-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e[P+I-1:I]));
        check("wr_data", 64'(wr_data), 64'(e[I-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = 0;
    @(negedge Clock);
    check("ready_after_start", 64'(byte_ready), 64'd1);
    check("done_after_start", 64'(done), 64'd0);
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
        tick();
      end
    end
    byte_valid = 1'b1;
    byte_in = b;
    n = 0;
    forever begin
      @(negedge Clock);
      acc = byte_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 50) begin
        check("byte_accept_timeout", 64'(n), 64'd0);
        break;
      end
    end
    if (gaps) byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [I-1:0] w, input bit gaps);
    exp_q.push_back({P'(exp_addr), w});
    img[exp_addr] = w;
    exp_addr++;
    for (int k = I / 8 - 1; k >= 0; k--) send_byte(w[k*8 +: 8], gaps);
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 20) begin
      @(negedge Clock);
      if (done) break;
      n++;
    end
    check("done_set", 64'(done), 64'd1);
    check("busy_clear", 64'(busy), 64'd0);
    check("ready_in_done", 64'(byte_ready), 64'd0);
    tick();
  endtask

  task automatic pulse_reset();
    nReset = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
    exp_addr = 0;
    tick();
  endtask

  initial begin
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values under random inputs.
    for (int c = 0; c < 5; c++) begin
      start = 1'($urandom); byte_valid = 1'($urandom); byte_in = 8'($urandom);
      @(negedge Clock);
      check("rst_outputs", 64'({byte_ready, wr_en, busy, done, wr_addr, wr_data}), 64'd0);
    end
    start = 1'b0; byte_valid = 1'b0;
    nReset = 1'b1;
    repeat (10) tick();
    @(negedge Clock);
    check("idle_ready", 64'(byte_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    tick();

    // Single word with exact strobe timing.
    do_start();
    exp_q.push_back({P'(0), 24'hABCDEF});
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'hEF, 1'b0);
    byte_valid = 1'b0;
    @(negedge Clock);
    check("single_wr_en", 64'(wr_en), 64'd1);
    tick();
    @(negedge Clock);
    check("single_ready_again", 64'(byte_ready), 64'd1);
    check("single_wr_en_drop", 64'(wr_en), 64'd0);
    check("single_sb_drain", 64'(exp_q.size()), 64'd0);
    pulse_reset();

    // Full load with random valid gaps.
    n_wr = 0;
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      logic [5:0] i6;
      logic [7:0] b0, b1, b2;
      i6 = 6'(i);
      b0 = 8'(i6); b1 = 8'(i6) + 8'd1; b2 = 8'(~i6);
      send_word({b0, b1, b2}, 1'b1);
    end
    wait_done();
    check("full_wr_count", 64'(n_wr), 64'(DEPTH));
    for (int a = 0; a < DEPTH; a++) check("image", 64'(tb_mem[a]), 64'(img[a]));

    // Restart from DONE with continuous valid; a stray start mid-RECV is ignored.
    n_wr = 0;
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) start = 1'b1;
      send_word(I'($urandom), 1'b0);
      start = 1'b0;
    end
    byte_valid = 1'b0;
    wait_done();
    check("bp_wr_count", 64'(n_wr), 64'(DEPTH));
    check("bp_sb_drain", 64'(exp_q.size()), 64'd0);

    // Reset mid-load after two bytes of word 5.
    do_start();
    for (int i = 0; i < 5; i++) send_word(I'($urandom), 1'b1);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    byte_valid = 1'b0;
    pulse_reset();
    repeat (5) tick();
    check("rst_sb_drain", 64'(exp_q.size()), 64'd0);
    @(negedge Clock);
    check("rst_idle_ready", 64'(byte_ready), 64'd0);
    tick();
    do_start();
    send_word(24'h123456, 1'b0);
    byte_valid = 1'b0;
    repeat (3) tick();
    check("post_rst_sb_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory loader: the write-side counterpart of the program ROM, which presents `instr` for a given `address`. It accepts a byte stream over a valid/ready handshake and assembles each group of `i_size/8` bytes MSB-first into one instruction word. It writes each word into a writable program memory at sequentially incrementing addresses from 0 to `(1<<p_size)-1`. It sits between a host/boot byte source and the program memory, and holds the processor off via `busy` while loading.

## Interface

Parameters:
- `p_size`, 6, program address width; the memory depth is `1<<p_size` words.
- `i_size`, 24, instruction width in bits. Must be a multiple of 8. Bytes per word `B = i_size/8` (3 by default).

Ports:
- `Clock`  in  1  single clock domain; all state changes on the rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE and DONE.
- `byte_in`  in  8  incoming byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  loader will accept `byte_in` this cycle.
- `wr_addr`  out  p_size  program memory write address.
- `wr_data`  out  i_size  program memory write data.
- `wr_en`  out  1  one-cycle write strobe to program memory.
- `busy`  out  1  load in progress; the processor must be held.
- `done`  out  1  full memory image written.

## Operation

- FSM states: IDLE, RECV, WRITE, DONE.
- Internal state:
  - address counter `addr` (p_size bits).
  - byte counter `bcnt` (width `$clog2(B)`, minimum 1).
  - shift register `shreg` (i_size bits).
- IDLE:
  - Outputs are all 0.
  - `start`=1 → RECV, with `addr`←0, `bcnt`←0, `shreg`←0.
- RECV:
  - `byte_ready`=1, `busy`=1.
  - A byte is accepted when `byte_valid && byte_ready` at a rising edge: `shreg`←{`shreg[i_size-9:0]`, `byte_in`} (first byte received ends up in bits [i_size-1:i_size-8]).
  - If `bcnt`==B-1, the accept moves to WRITE and sets `bcnt`←0. Otherwise `bcnt`←`bcnt`+1.
  - `byte_valid` without `byte_ready` has no effect.
- WRITE:
  - `byte_ready`=0, `busy`=1, `wr_en`=1 for exactly one cycle.
  - `wr_addr`=`addr`, `wr_data`=`shreg`.
  - If `addr`==(1<<p_size)-1 → DONE. Otherwise `addr`←`addr`+1 and → RECV.
- DONE:
  - `done`=1, `busy`=0, `byte_ready`=0.
  - Remains in DONE until `start`=1, which behaves exactly as from IDLE (→ RECV, counters cleared, `done` drops the next cycle).
- `start` is ignored in RECV and WRITE.
- `addr` never wraps within one load; the final write is at address `(1<<p_size)-1`.
- `wr_addr` and `wr_data` hold their last values outside WRITE. They are meaningful only while `wr_en`=1.
- Bytes arriving outside RECV are not consumed; the source must hold them until `byte_ready`.

## Timing

- Reset (nReset=0, asynchronous):
  - state=IDLE; `addr`, `bcnt`, `shreg` = 0.
  - `byte_ready`, `wr_en`, `busy`, `done` = 0; `wr_addr`=0; `wr_data`=0.
- Reset asserted mid-load discards any partial word. Writes already issued stand. After release the loader is in IDLE and requires a new `start`.
- All outputs are decoded from registered state only: no combinational path from any input to any output.
- `start` seen at edge N → `byte_ready`=1 in cycle N+1.
- The B-th byte of a word accepted at edge M → `wr_en`=1 in cycle M+1 → `byte_ready`=1 again in cycle M+2.
- Minimum cycles per word is B+1 (4 by default). A full default load takes at least 64×4 = 256 cycles after `start`.
- The source may deassert `byte_valid` at any time; stalls of any length in RECV are legal and lose no state.

## Test plan

- Reset values: hold nReset=0 with random inputs → every output is 0. Release, then drive no `start` for 10 cycles → still IDLE, `byte_ready`=0.
- Single word: `start`, then bytes 0xAB, 0xCD, 0xEF back-to-back → exactly one `wr_en` pulse with `wr_addr`=0, `wr_data`=0xABCDEF, one cycle after the third accept.
- Full load with gaps: `start`, stream 192 bytes forming words `{i[5:0],i[5:0]+1,~i[5:0]}` for i=0..63, with `byte_valid` toggled randomly. Check the resulting memory image against the ROM read-back loop (all 64 addresses match), 64 `wr_en` pulses total, `done`=1, `busy`=0.
- Backpressure: hold `byte_valid`=1 continuously → `byte_ready`=0 during every WRITE cycle, and no byte is lost or duplicated (check `wr_data` sequence).
- Reset mid-operation: after 2 bytes of word 5, pulse nReset low → no `wr_en` for the partial word. Then `start` and 3 bytes → write at `wr_addr`=0.
- Restart and ignore: `start` asserted during RECV has no effect on `addr`. `start` in DONE → `done`=0 the next cycle and the load restarts at address 0.
